// File: rtl/wb_timer_pkg.sv
// Shared constants for the Wishbone timer: register word indices, CTRL bit positions, prescaler width.
package wb_timer_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESCALE = 2'd1;
    localparam logic [1:0] REG_RELOAD   = 2'd2;
    localparam logic [1:0] REG_COUNT    = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CTRL_IE  = 2;
    localparam int CTRL_EXP = 8;

    localparam int PRESC_W = 16;

    // Byte-lane write: lanes with sel set take the new data, others keep the old value.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_val & ~mask) | (wdat & mask);
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Clock divider: tick is combinational, high in the cycle the count equals limit; count then wraps.
// Holds while disabled; clear forces the count back to 0 on the next edge.
module wb_timer_prescaler
    import wb_timer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic [PRESC_W-1:0] limit,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = enable & (cnt == limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Wishbone B4 classic down-counting timer: ack one edge after a hit, one ack per strobe even if held.
// Misses are never acked; irq is registered from the sticky expiry flag and irq enable.
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [31:0] address = 32'h0300_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic        irq
);

    logic               en, ar, ie, expired;
    logic [PRESC_W-1:0] prescale;
    logic [31:0]        reload, count;
    logic               served;

    logic        req, hit, wr;
    logic [1:0]  reg_idx;
    logic        wr_ctrl, wr_prescale, wr_reload, wr_count;
    logic        en_rise, tick, expire;
    logic [31:0] prescale_wr, reload_wr, count_wr, rdata;
    logic        unused_ok;

    assign req     = i_wb_cyc & i_wb_stb;
    assign reg_idx = i_wb_addr[3:2];
    // served blocks a second ack while the master keeps the same strobe asserted
    assign hit     = req & (i_wb_addr[31:4] == address[31:4]) & ~o_wb_ack & ~served;
    assign wr      = hit & i_wb_we;

    assign wr_ctrl     = wr & (reg_idx == REG_CTRL);
    assign wr_prescale = wr & (reg_idx == REG_PRESCALE);
    assign wr_reload   = wr & (reg_idx == REG_RELOAD);
    assign wr_count    = wr & (reg_idx == REG_COUNT);

    assign en_rise = wr_ctrl & i_wb_sel[0] & i_wb_data[CTRL_EN] & ~en;
    assign expire  = tick & (count == 32'd0);

    assign prescale_wr = lane_merge({{(32-PRESC_W){1'b0}}, prescale}, i_wb_data, i_wb_sel);
    assign reload_wr   = lane_merge(reload, i_wb_data, i_wb_sel);
    assign count_wr    = lane_merge(count, i_wb_data, i_wb_sel);

    assign unused_ok = &{1'b0, i_wb_addr[1:0], prescale_wr[31:PRESC_W]};

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL: begin
                rdata[CTRL_EN]  = en;
                rdata[CTRL_AR]  = ar;
                rdata[CTRL_IE]  = ie;
                rdata[CTRL_EXP] = expired;
            end
            REG_PRESCALE: rdata[PRESC_W-1:0] = prescale;
            REG_RELOAD:   rdata = reload;
            default:      rdata = count;
        endcase
    end

    wb_timer_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (en),
        .clear  (en_rise | wr_count),
        .limit  (prescale),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
            irq       <= 1'b0;
            served    <= 1'b0;
            en        <= 1'b0;
            ar        <= 1'b0;
            ie        <= 1'b0;
            expired   <= 1'b0;
            prescale  <= '0;
            reload    <= '0;
            count     <= '0;
        end else begin
            o_wb_ack  <= hit;
            o_wb_data <= hit ? rdata : '0;
            served    <= req & (served | hit);
            irq       <= expired & ie;

            // a new expiry in the same cycle beats the write-one-to-clear
            expired <= (expired & ~(wr_ctrl & i_wb_sel[1] & i_wb_data[CTRL_EXP])) | expire;

            if (wr_ctrl && i_wb_sel[0]) begin
                en <= i_wb_data[CTRL_EN];
                ar <= i_wb_data[CTRL_AR];
                ie <= i_wb_data[CTRL_IE];
            end else if (expire && !ar) begin
                en <= 1'b0;
            end

            if (wr_prescale) prescale <= prescale_wr[PRESC_W-1:0];
            if (wr_reload)   reload   <= reload_wr;

            if (wr_count) begin
                count <= count_wr;
            end else if (tick) begin
                if (count != 32'd0) count <= count - 32'd1;
                else                count <= ar ? reload : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed bench for wb_timer with a cycle-level behavioural model and per-cycle output comparison.
module tb_wb_timer;

    localparam logic [31:0] BASE = 32'h0300_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] addr, wdat;
    logic        o_ack;
    logic [31:0] o_dat;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;
    bit chk_on = 1'b0;

    wb_timer #(.address(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_sel  (sel),
        .i_wb_addr (addr),
        .i_wb_data (wdat),
        .o_wb_ack  (o_ack),
        .o_wb_data (o_dat),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en, m_ar, m_ie, m_exp, m_served, m_ack, m_irq;
    logic [15:0] m_pre, m_pc;
    logic [31:0] m_rel, m_cnt, m_dat;

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask = 0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        return (old_val & ~mask) | (d & mask);
    endfunction

    always @(posedge clk) begin
        logic        req, hit, tick, expiring;
        logic [1:0]  idx;
        logic [31:0] rv, tmp;
        logic        n_en, n_ar, n_ie, n_exp;
        logic [15:0] n_pre, n_pc;
        logic [31:0] n_rel, n_cnt;
        cycle++;
        if (reset) begin
            m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_served = 0; m_ack = 0; m_irq = 0;
            m_pre = 0; m_pc = 0; m_rel = 0; m_cnt = 0; m_dat = 0;
        end else begin
            req = cyc && stb;
            hit = req && ((addr >> 4) == (BASE >> 4)) && !m_served;
            idx = addr[3:2];
            case (idx)
                2'd0: rv = 256 * m_exp + 4 * m_ie + 2 * m_ar + m_en;
                2'd1: rv = {16'h0, m_pre};
                2'd2: rv = m_rel;
                default: rv = m_cnt;
            endcase
            tick     = m_en && (m_pc == m_pre);
            expiring = tick && (m_cnt == 0);
            n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_exp = m_exp;
            n_pre = m_pre; n_rel = m_rel; n_cnt = m_cnt; n_pc = m_pc;
            if (m_en) n_pc = tick ? 16'd0 : m_pc + 16'd1;
            if (tick) begin
                if (m_cnt != 0) n_cnt = m_cnt - 1;
                else begin
                    n_exp = 1;
                    if (m_ar) n_cnt = m_rel;
                    else      n_en = 0;
                end
            end
            if (hit && we) begin
                case (idx)
                    2'd0: begin
                        if (sel[0]) begin
                            if (!m_en && wdat[0]) n_pc = 0;
                            n_en = wdat[0]; n_ar = wdat[1]; n_ie = wdat[2];
                        end
                        if (sel[1] && wdat[8] && !expiring) n_exp = 0;
                    end
                    2'd1: begin tmp = merge({16'h0, m_pre}, wdat, sel); n_pre = tmp[15:0]; end
                    2'd2: n_rel = merge(m_rel, wdat, sel);
                    default: begin n_cnt = merge(m_cnt, wdat, sel); n_pc = 0; end
                endcase
            end
            m_irq    = m_exp && m_ie;
            m_ack    = hit;
            m_dat    = hit ? rv : 32'h0;
            m_served = req && (m_served || hit);
            m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_exp = n_exp;
            m_pre = n_pre; m_rel = n_rel; m_cnt = n_cnt; m_pc = n_pc;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_ack", {31'h0, o_ack}, {31'h0, m_ack});
            chk("cyc_data", o_dat, m_dat);
            chk("cyc_irq", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; addr = a; wdat = d; sel = s;
        lat = 0; rd = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (o_ack) begin lat = i; rd = o_dat; break; end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; int lat;
        wb(1'b1, BASE + off, d, s, rd, lat);
        chk("wr_lat", lat, 1);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd; int lat;
        wb(1'b0, BASE + off, 32'h0, 4'h0, rd, lat);
        chk({nm, "_lat"}, lat, 1);
        chk(nm, rd, exp);
    endtask

    task automatic wait_irq(output int waited);
        waited = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (irq) begin waited = i; break; end
        end
    endtask

    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, w, pulses, lat;
        logic [31:0] rd;
        reset = 1; cyc = 0; stb = 0; we = 0; sel = 0; addr = 0; wdat = 0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        chk("rst_ack", {31'h0, o_ack}, 0);
        chk("rst_irq", {31'h0, irq}, 0);
        reset = 0;

        rd_chk("rst_ctrl", 32'h0, 32'h0);
        rd_chk("rst_prescale", 32'h4, 32'h0);
        rd_chk("rst_reload", 32'h8, 32'h0);
        rd_chk("rst_count", 32'hC, 32'h0);

        // byte lanes
        wr(32'h8, 32'h1122_3344, 4'hF);
        wr(32'h8, 32'hAABB_CCDD, 4'b0001);
        rd_chk("lane_sel1", 32'h8, 32'h1122_33DD);
        wr(32'h8, 32'hAABB_CCDD, 4'b1100);
        rd_chk("lane_selC", 32'h8, 32'hAABB_33DD);
        wr(32'h8, 32'h0000_0000, 4'b0000);
        rd_chk("lane_sel0", 32'h8, 32'hAABB_33DD);

        // periodic: (4+1)*(3+1) = 20 clocks per expiry, irq one register later
        wr(32'h4, 32'd3, 4'hF);
        wr(32'h8, 32'd4, 4'hF);
        wr(32'hC, 32'd4, 4'hF);
        wr(32'h0, 32'h7, 4'hF);
        t0 = cycle;
        wait_irq(w);
        t1 = cycle;
        chk("per_first_irq", t1 - t0, 21);
        wr(32'h0, 32'h107, 4'hF);
        chk("per_irq_w1c_edge", {31'h0, irq}, 1);
        @(negedge clk);
        chk("per_irq_drop", {31'h0, irq}, 0);
        wait_irq(w);
        t2 = cycle;
        chk("per_period", t2 - t1, 20);
        wr(32'h0, 32'h100, 4'b0011);

        // one-shot
        wr(32'h4, 32'd0, 4'hF);
        wr(32'hC, 32'd2, 4'hF);
        wr(32'h0, 32'h5, 4'hF);
        t0 = cycle;
        wait_irq(w);
        chk("os_irq_delay", cycle - t0, 4);
        rd_chk("os_ctrl", 32'h0, 32'h104);
        rd_chk("os_count", 32'hC, 32'h0);
        repeat (50) @(negedge clk);
        rd_chk("os_ctrl_late", 32'h0, 32'h104);
        rd_chk("os_count_late", 32'hC, 32'h0);
        wr(32'h0, 32'h100, 4'b0010);

        // unmapped address never acks
        wb(1'b0, 32'h0300_0110, 32'h0, 4'h0, rd, lat);
        chk("miss_ack_lat", lat, 0);

        // strobe held for 5 cycles gives one ack
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; addr = BASE + 32'h8;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_ack) pulses++;
        end
        cyc = 0; stb = 0;
        chk("hold_acks", pulses, 1);

        // COUNT write on a tick edge: prescaler runs 0..3 after enable, tick at 4th edge
        wr(32'h4, 32'd3, 4'hF);
        wr(32'hC, 32'd100, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        wr(32'hC, 32'd9, 4'hF);
        rd_chk("cnt_on_tick", 32'hC, 32'd9);
        wr(32'h0, 32'h0, 4'b0001);

        // W1C on the expiry edge: expiry wins
        wr(32'h4, 32'd0, 4'hF);
        wr(32'hC, 32'd1, 4'hF);
        wr(32'h0, 32'h1, 4'hF);
        wr(32'h0, 32'h100, 4'b0010);
        rd_chk("w1c_collide", 32'h0, 32'h100);
        wr(32'h0, 32'h100, 4'b0010);

        // reset in the middle of a running count and a bus write
        wr(32'h4, 32'd2, 4'hF);
        wr(32'hC, 32'd0, 4'hF);
        wr(32'h0, 32'h7, 4'hF);
        repeat (6) @(negedge clk);
        wr(32'hC, 32'h55, 4'hF);
        chk("pre_rst_irq", {31'h0, irq}, 1);
        @(negedge clk);
        reset = 1; cyc = 1; stb = 1; we = 1; addr = BASE + 32'hC; wdat = 32'h77; sel = 4'hF;
        @(negedge clk);
        chk("mid_rst_ack", {31'h0, o_ack}, 0);
        chk("mid_rst_irq", {31'h0, irq}, 0);
        reset = 0; cyc = 0; stb = 0; we = 0;
        rd_chk("post_rst_ctrl", 32'h0, 32'h0);
        rd_chk("post_rst_prescale", 32'h4, 32'h0);
        rd_chk("post_rst_reload", 32'h8, 32'h0);
        rd_chk("post_rst_count", 32'hC, 32'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
